// File: rtl/sti_dac_gen_pkg.sv
// sti_dac_gen shared types and helpers.
// Frame length code decode and image checkerboard bank parity.
package sti_dac_gen_pkg;

  localparam int MAX_LEN_DEF = 32;
  localparam int LEN_W = $clog2(MAX_LEN_DEF / 8);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
    FLUSH,
    DONE
  } tx_state_t;

  function automatic int unsigned len_bits(
    input logic [LEN_W-1:0] code
  );
    return (32'(code) + 32'd1) * 32'd8;
  endfunction

  // 1 selects the odd bank: column and row parities agree
  function automatic logic odd_sel(
    input int unsigned j,
    input int unsigned row_pix
  );
    int unsigned col;
    int unsigned row;
    col = j % row_pix;
    row = j / row_pix;
    return ((col ^ row) & 32'd1) == 32'd0;
  endfunction

endpackage

// File: rtl/sti_dac_gen_packer.sv
// sti_dac_gen byte assembler, bank/address generator and flush sequencer.
// Optional wr_count output under STI_DAC_GEN_STATUS_EN.
module sti_dac_gen_packer
  import sti_dac_gen_pkg::*;
#(
  parameter int NBANK      = 4,
  parameter int BANK_DEPTH = 32,
  parameter int ROW_PIX    = 8,
  parameter int TOTAL      = 2 * BANK_DEPTH * NBANK,
  parameter int CNT_W      = $clog2(TOTAL + 1),
  localparam int AW = $clog2(BANK_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_data,
  input  logic             flush,
  output logic             full,
  output logic [NBANK-1:0] odd_wr,
  output logic [NBANK-1:0] even_wr,
  output logic [AW-1:0]    oem_addr,
  output logic [7:0]       oem_dataout,
  output logic             oem_finish
`ifdef STI_DAC_GEN_STATUS_EN
  , output logic [CNT_W-1:0] wr_count
`endif
);

  localparam int JW = $clog2(2 * BANK_DEPTH);
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

  logic [7:0]       shreg;
  logic [7:0]       wbyte;
  logic [2:0]       bcnt;
  logic [3:0]       pad;
  logic [CNT_W-1:0] n;
  logic [JW-1:0]    j;
  logic [BW-1:0]    bank;
  logic [NBANK-1:0] onehot;
  logic             strobe_q;
  logic             data_wr;
  logic             flush_wr;
  logic             issue;
  logic             sel_odd;

  always_comb begin
    full     = (n == CNT_W'(TOTAL));
    strobe_q = (|odd_wr) | (|even_wr);
    data_wr  = bit_valid && (bcnt == 3'd7) && !full;
    // flush writes alternate with an idle cycle
    flush_wr = flush && !full && !strobe_q && !bit_valid;
    issue    = data_wr | flush_wr;
    pad      = 4'd8 - {1'b0, bcnt};
    wbyte    = data_wr ? {shreg[6:0], bit_data} : (shreg << pad);
    j        = n[JW-1:0];
    bank     = n[JW +: BW];
    sel_odd  = odd_sel(32'(j), ROW_PIX);
    onehot   = NBANK'(1) << bank;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      bcnt        <= '0;
      n           <= '0;
      odd_wr      <= '0;
      even_wr     <= '0;
      oem_addr    <= '0;
      oem_dataout <= '0;
      oem_finish  <= 1'b0;
    end else begin
      if (bit_valid) begin
        shreg <= {shreg[6:0], bit_data};
        bcnt  <= bcnt + 3'd1;
      end else if (flush_wr) begin
        bcnt <= '0;
      end
      odd_wr  <= '0;
      even_wr <= '0;
      if (issue) begin
        n           <= n + CNT_W'(1);
        oem_addr    <= j[JW-1:1];
        oem_dataout <= wbyte;
        if (sel_odd) odd_wr <= onehot;
        else         even_wr <= onehot;
      end
      if (strobe_q && full) oem_finish <= 1'b1;
    end
  end

`ifdef STI_DAC_GEN_STATUS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
    end else if (issue && (wr_count != CNT_W'(TOTAL))) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/sti_dac_gen.sv
// sti_dac_gen: handshake, frame capture and serialiser feeding the packer.
// Optional wr_count status port under STI_DAC_GEN_STATUS_EN.
module sti_dac_gen
  import sti_dac_gen_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int MAX_LEN    = 32,
  parameter int NBANK      = 4,
  parameter int BANK_DEPTH = 32,
  parameter int ROW_PIX    = 8,
  parameter int GAP_CYC    = 3,
  localparam int TOTAL = 2 * BANK_DEPTH * NBANK,
  localparam int AW    = $clog2(BANK_DEPTH),
  localparam int CNT_W = $clog2(TOTAL + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pi_valid,
  output logic              pi_ready,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [LEN_W-1:0]  pi_length,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_low,
  input  logic              pi_end,
  output logic              so_data,
  output logic              so_valid,
  output logic [NBANK-1:0]  odd_wr,
  output logic [NBANK-1:0]  even_wr,
  output logic [AW-1:0]     oem_addr,
  output logic [7:0]        oem_dataout,
  output logic              oem_finish
`ifdef STI_DAC_GEN_STATUS_EN
  , output logic [CNT_W-1:0] wr_count
`endif
);

  localparam int BCW = $clog2(MAX_LEN + 1);
  localparam int GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  tx_state_t          state;
  tx_state_t          nxt;
  logic [MAX_LEN-1:0] sh;
  logic [MAX_LEN-1:0] word;
  logic [MAX_LEN-1:0] frame;
  logic [MAX_LEN-1:0] load;
  logic [BCW-1:0]     bcnt;
  logic [GW-1:0]      gcnt;
  logic               msb_q;
  logic               end_q;
  logic               accept;
  logic               full;
  int unsigned        len;

  assign pi_ready = (state == IDLE) & ~reset;
  assign accept   = pi_valid & pi_ready;
  assign so_valid = (state == SHIFT);
  assign so_data  = so_valid & (msb_q ? sh[MAX_LEN-1] : sh[0]);

  // load is left-aligned for MSB-first so both orders shift a fixed end
  always_comb begin
    len   = len_bits(pi_length);
    word  = MAX_LEN'(pi_data);
    frame = word;
    unique case (1'b1)
      (len < DATA_W):
        frame = pi_low
              ? (word >> (DATA_W - len))
              : (word & ((MAX_LEN'(1) << len) - MAX_LEN'(1)));
      (len == DATA_W):
        frame = word;
      (len > DATA_W):
        frame = pi_fill ? (word << (len - DATA_W)) : word;
      default:
        frame = word;
    endcase
    load = pi_msb ? (frame << (MAX_LEN - len)) : frame;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (accept) nxt = SHIFT;
      SHIFT: if (bcnt == BCW'(1)) nxt = GAP;
      GAP:
        if (gcnt == GW'(GAP_CYC - 1))
          nxt = !end_q ? IDLE : (full ? DONE : FLUSH);
      FLUSH: if (full) nxt = DONE;
      DONE:  nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      bcnt  <= '0;
      gcnt  <= '0;
      msb_q <= 1'b0;
      end_q <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        sh    <= load;
        bcnt  <= BCW'(len);
        msb_q <= pi_msb;
        end_q <= pi_end;
      end else if (state == SHIFT) begin
        sh   <= msb_q ? (sh << 1) : (sh >> 1);
        bcnt <= bcnt - BCW'(1);
      end
      gcnt <= (state == GAP) ? gcnt + GW'(1) : '0;
    end
  end

  sti_dac_gen_packer #(
    .NBANK      (NBANK),
    .BANK_DEPTH (BANK_DEPTH),
    .ROW_PIX    (ROW_PIX),
    .TOTAL      (TOTAL),
    .CNT_W      (CNT_W)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .bit_valid   (so_valid),
    .bit_data    (so_data),
    .flush       (state == FLUSH),
    .full        (full),
    .odd_wr      (odd_wr),
    .even_wr     (even_wr),
    .oem_addr    (oem_addr),
    .oem_dataout (oem_dataout),
    .oem_finish  (oem_finish)
`ifdef STI_DAC_GEN_STATUS_EN
    , .wr_count  (wr_count)
`endif
  );

endmodule

// File: doc/sti_dac_gen.md
Name: sti_dac_gen

Overview:
Parametrised serial transmitter plus data-arrangement controller.
- Accepts parallel words over a valid/ready handshake.
- Serialises each word as a frame of 8..MAX_LEN bits with fill, bit-order and half-select options.
- Repacks the bit stream into bytes and scatters them across NBANK odd/even memory bank pairs in image checkerboard order.
- On end-of-stream, flushes all remaining addresses with 0x00 and asserts oem_finish.
- Sits between the host data port and the output memories.

Parameters:
DATA_W, 16, parallel input word width (multiple of 8)
MAX_LEN, 32, maximum frame length in bits (multiple of 8, >= DATA_W)
NBANK, 4, number of odd/even bank pairs
BANK_DEPTH, 32, bytes per bank (power of two)
ROW_PIX, 8, pixels per image row (even power of two)
GAP_CYC, 3, idle cycles between frames

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
pi_valid  in  1  word offered
pi_ready  out  1  block can accept a word
pi_data  in  DATA_W  parallel word
pi_length  in  LEN_W=$clog2(MAX_LEN/8)  frame length L=(pi_length+1)*8 bits
pi_fill  in  1  L>DATA_W: 1=data in upper DATA_W bits, 0=data in lower bits
pi_msb  in  1  1=MSB-first serialisation
pi_low  in  1  L<DATA_W: 1=use pi_data[DATA_W-1 -: L], 0=use pi_data[L-1:0]
pi_end  in  1  this word is the last of the stream
so_data  out  1  serial bit
so_valid  out  1  serial bit valid
odd_wr  out  NBANK  odd-bank write strobes (one-hot or zero)
even_wr  out  NBANK  even-bank write strobes (one-hot or zero)
oem_addr  out  $clog2(BANK_DEPTH)  write address
oem_dataout  out  8  write data
oem_finish  out  1  all bank locations written; sticky

Behaviour:
Reset, clock:
- Reset is asynchronous and active-high; clock is clk.
- Reset drives all outputs to 0 except pi_ready, which is 1 in the first cycle after release.
- Reset mid-operation abandons the frame, the partial byte and the byte pointer.

Transmitter FSM: IDLE -> SHIFT -> GAP -> (IDLE | FLUSH); FLUSH -> DONE.
- IDLE: pi_ready=1. On pi_valid&&pi_ready, capture all pi_* and go to SHIFT.
- SHIFT: so_valid=1 for exactly L consecutive cycles. The first bit appears the cycle after acceptance.
- Frame construction:
  - L<DATA_W: selected per pi_low.
  - L==DATA_W: whole word.
  - L>DATA_W: zero-padded per pi_fill.
- Bit order: pi_msb=1 sends frame bit L-1 first; pi_msb=0 sends bit 0 first.
- GAP: GAP_CYC cycles with so_valid=0 and pi_ready=0. Then go to FLUSH if the captured pi_end=1, else IDLE.
- pi_ready=0 in FLUSH and DONE. pi_valid is ignored there.

Packer:
- The first received bit of each byte becomes bit 7.
- The cycle after the 8th bit, one write is issued: strobe, oem_addr and oem_dataout are valid in the same cycle. Strobes are single-cycle.
- Byte counter n runs 0..TOTAL-1, where TOTAL=2*BANK_DEPTH*NBANK.
  - bank = n/(2*BANK_DEPTH)
  - j = n mod 2*BANK_DEPTH
  - oem_addr = j>>1
  - col = j mod ROW_PIX
  - row = j/ROW_PIX
- Bank select: (col^row) LSB = 0 -> odd_wr[bank], else even_wr[bank].
- Bits arriving after n reaches TOTAL are discarded; no strobe is issued.

FLUSH:
- A partial byte is zero-padded in its low bits and written first.
- Then 0x00 is written to every remaining n, one write every 2 cycles (strobe, idle).
- oem_finish rises the cycle after the write with n=TOTAL-1 and stays high until reset. This also applies if capacity is reached by data alone.
- A stream-end (pi_end) frame with n already at TOTAL goes straight to DONE.

Optional Feature:
Macro STI_DAC_GEN_STATUS_EN.
- Defined: adds output wr_count [$clog2(TOTAL+1)] counting issued write strobes (data and flush), reset 0, saturating at TOTAL.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package sti_dac_gen_pkg holds:
  - tx_state_t enum (IDLE, SHIFT, GAP, FLUSH, DONE)
  - LEN_W
  - function len_bits(code)
  - function odd_sel(j) (checkerboard)
- Sub-module sti_dac_gen_packer contains the byte assembler, address/bank generator and flush sequencer.
- The top module holds the handshake, capture and serialiser.

Test Plan:
1. 16'hA5C3, len=0, low=1, msb=1 -> so_data 1,0,1,0,0,1,0,1 over 8 cycles; then odd_wr[0] pulse, addr 0, data 0xA5.
2. 16'h1234, len=2, fill=1, msb=0 -> 8 zeros, then 16'h1234 LSB-first (0,0,1,0,1,1,0,0,...); so_valid high for 24 cycles; GAP 3 cycles with pi_ready=0.
3. Nine 8-bit frames 0x01..0x09, msb=1, low=0 -> writes: odd0@0=01, even0@0=02, odd0@1=03, even0@1=04, odd0@2=05, even0@2=06, odd0@3=07, even0@3=08, even0@4=09 (row 1 flips parity).
4. Single 8-bit frame with pi_end=1 -> 1 data write plus 255 flush writes at 2-cycle spacing; last write odd_wr[3] addr 31 data 0; oem_finish high next cycle and held.
5. Assert reset at bit 5 of a 32-bit frame -> all outputs 0 immediately; pi_ready=1 after release; next byte goes to odd_wr[0] addr 0.
6. With STI_DAC_GEN_STATUS_EN defined, the scenario 4 stimulus -> wr_count=256 when oem_finish rises.
